// File: rtl/dehaze_pkg.sv
// Shared types and helpers for the dehaze atmospheric-light frame path.
package dehaze_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        WAIT_A = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_IMG_WIDTH  = 320;
    localparam int DEF_IMG_HEIGHT = 240;

    // Width of a counter covering 0..n-1, never narrower than one bit.
    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dehaze_a_smoother.sv
// Combinational IIR step: moves the current A toward the new A by (new-cur)>>>shift.
module a_smoother
    import dehaze_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_a_cur,
    input  logic [DATA_WIDTH-1:0] i_a_new,
    input  logic [3:0]            i_shift,
    output logic [DATA_WIDTH-1:0] o_a_next
);

    logic signed [DATA_WIDTH:0] w_diff;
    logic signed [DATA_WIDTH:0] w_step;

    // Floored step keeps the result between old and new, so the low bits of the sum are exact.
    assign w_diff   = $signed({1'b0, i_a_new}) - $signed({1'b0, i_a_cur});
    assign w_step   = w_diff >>> i_shift;
    assign o_a_next = i_a_cur + w_step[DATA_WIDTH-1:0];

endmodule

// File: rtl/dehaze_frame_ctrl.sv
// Frame sequencer: pixel position tracking, estimator clear, A capture/smoothing, fault flags.
module dehaze_frame_ctrl
    import dehaze_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
    parameter int SMOOTH_SHIFT = 2,
    parameter int TIMEOUT      = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             vsync,
    input  logic                             hsync,
    input  logic                             valid_in,
    input  logic [DATA_WIDTH-1:0]            a_new,
    input  logic                             a_new_valid,
    output logic                             calc_clr,
    output logic                             sof,
    output logic                             eof,
    output logic [coord_w(IMG_WIDTH)-1:0]    x_pos,
    output logic [coord_w(IMG_HEIGHT)-1:0]   y_pos,
    output logic [DATA_WIDTH-1:0]            a_cur,
    output logic                             a_cur_valid,
    output logic                             frame_err,
    output logic [15:0]                      frame_cnt
);

    localparam int XW = coord_w(IMG_WIDTH);
    localparam int YW = coord_w(IMG_HEIGHT);
    localparam int TW = coord_w(TIMEOUT);
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_t                r_state, w_state_nxt;
    logic                  r_vsync_d, r_hsync_d;
    logic                  w_vs_rise, w_hs_rise;
    logic [XW-1:0]         r_x, w_x_nxt;
    logic [YW-1:0]         r_y, w_y_nxt;
    logic [TW-1:0]         r_to, w_to_nxt;
    logic                  r_sof, r_calc_clr, r_eof, r_err;
    logic                  w_sof_nxt, w_eof_nxt, w_err_nxt, w_a_take;
    logic [DATA_WIDTH-1:0] r_a_cur, w_a_smooth, w_a_next;
    logic                  r_a_valid;
    logic [15:0]           r_frame_cnt;

    assign w_vs_rise = vsync & ~r_vsync_d;
    assign w_hs_rise = hsync & ~r_hsync_d;

    a_smoother #(.DATA_WIDTH(DATA_WIDTH)) u_a_smoother (
        .i_a_cur  (r_a_cur),
        .i_a_new  (a_new),
        .i_shift  (4'(SMOOTH_SHIFT)),
        .o_a_next (w_a_smooth)
    );

    // The first capture seeds the filter directly.
    assign w_a_next = r_a_valid ? w_a_smooth : a_new;

    // Next-state, counter and pulse decode.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_to_nxt    = {TW{1'b0}};
        w_sof_nxt   = 1'b0;
        w_eof_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_a_take    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_vs_rise) begin
                    w_sof_nxt   = 1'b1;
                    w_x_nxt     = {XW{1'b0}};
                    w_y_nxt     = {YW{1'b0}};
                    w_state_nxt = ACTIVE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACTIVE: begin
                if (w_vs_rise) begin
                    w_err_nxt = 1'b1;
                    w_sof_nxt = 1'b1;
                    w_x_nxt   = {XW{1'b0}};
                    w_y_nxt   = {YW{1'b0}};
                end else if (valid_in) begin
                    if (r_x == X_LAST) begin
                        w_x_nxt = {XW{1'b0}};
                        if (r_y == Y_LAST) begin
                            w_y_nxt     = {YW{1'b0}};
                            w_eof_nxt   = 1'b1;
                            w_state_nxt = WAIT_A;
                        end else begin
                            w_y_nxt = r_y + YW'(1);
                        end
                    end else begin
                        w_x_nxt = r_x + XW'(1);
                    end
                end else begin
                    w_state_nxt = ACTIVE;
                end
                w_err_nxt = w_err_nxt | (w_hs_rise & (r_x != {XW{1'b0}}));
            end
            WAIT_A: begin
                if (a_new_valid) begin
                    w_a_take = 1'b1;
                    if (w_vs_rise) begin
                        w_sof_nxt   = 1'b1;
                        w_x_nxt     = {XW{1'b0}};
                        w_y_nxt     = {YW{1'b0}};
                        w_state_nxt = ACTIVE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_vs_rise) begin
                    w_err_nxt   = 1'b1;
                    w_sof_nxt   = 1'b1;
                    w_x_nxt     = {XW{1'b0}};
                    w_y_nxt     = {YW{1'b0}};
                    w_state_nxt = ACTIVE;
                end else if (r_to == TO_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_to_nxt = r_to + TW'(1);
                end
                // Extra pixels after the frame are dropped but flagged.
                w_err_nxt = w_err_nxt | (valid_in & ~w_vs_rise);
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters, A result and registered output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_vsync_d   <= 1'b0;
            r_hsync_d   <= 1'b0;
            r_x         <= {XW{1'b0}};
            r_y         <= {YW{1'b0}};
            r_to        <= {TW{1'b0}};
            r_sof       <= 1'b0;
            r_calc_clr  <= 1'b0;
            r_eof       <= 1'b0;
            r_err       <= 1'b0;
            r_a_cur     <= {DATA_WIDTH{1'b0}};
            r_a_valid   <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_vsync_d  <= vsync;
            r_hsync_d  <= hsync;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_to       <= w_to_nxt;
            r_sof      <= w_sof_nxt;
            r_calc_clr <= w_sof_nxt;
            r_eof      <= w_eof_nxt;
            r_err      <= w_err_nxt;
            if (w_a_take) begin
                r_a_cur     <= w_a_next;
                r_a_valid   <= 1'b1;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
                r_a_cur     <= r_a_cur;
                r_a_valid   <= r_a_valid;
                r_frame_cnt <= r_frame_cnt;
            end
        end
    end

    assign calc_clr    = r_calc_clr;
    assign sof         = r_sof;
    assign eof         = r_eof;
    assign x_pos       = r_x;
    assign y_pos       = r_y;
    assign a_cur       = r_a_cur;
    assign a_cur_valid = r_a_valid;
    assign frame_err   = r_err;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_dehaze_frame_ctrl.sv
// Bench for dehaze_frame_ctrl on a 4x2 frame with a scoreboard of expected A values.
`timescale 1ns/1ps
module tb_dehaze_frame_ctrl;
    import dehaze_pkg::*;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int TO = 16;
    localparam int XW = coord_w(W);
    localparam int YW = coord_w(H);

    logic          clk = 1'b0;
    logic          rst_n, vsync, hsync, valid_in, a_new_valid;
    logic [DW-1:0] a_new;
    logic          calc_clr, sof, eof, a_cur_valid, frame_err;
    logic [XW-1:0] x_pos;
    logic [YW-1:0] y_pos;
    logic [DW-1:0] a_cur;
    logic [15:0]   frame_cnt;
    logic          z_calc_clr, z_sof, z_eof, z_a_cur_valid, z_frame_err;
    logic [XW-1:0] z_x_pos;
    logic [YW-1:0] z_y_pos;
    logic [DW-1:0] z_a_cur;
    logic [15:0]   z_frame_cnt;
    logic [DW-1:0] sm_cur, sm_new, sm_next;
    logic [3:0]    sm_shift;

    dehaze_frame_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H),
                        .SMOOTH_SHIFT(2), .TIMEOUT(TO)) u_dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .hsync(hsync), .valid_in(valid_in),
        .a_new(a_new), .a_new_valid(a_new_valid), .calc_clr(calc_clr), .sof(sof),
        .eof(eof), .x_pos(x_pos), .y_pos(y_pos), .a_cur(a_cur), .a_cur_valid(a_cur_valid),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    dehaze_frame_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H),
                        .SMOOTH_SHIFT(0), .TIMEOUT(TO)) u_dut_noshift (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .hsync(hsync), .valid_in(valid_in),
        .a_new(a_new), .a_new_valid(a_new_valid), .calc_clr(z_calc_clr), .sof(z_sof),
        .eof(z_eof), .x_pos(z_x_pos), .y_pos(z_y_pos), .a_cur(z_a_cur),
        .a_cur_valid(z_a_cur_valid), .frame_err(z_frame_err), .frame_cnt(z_frame_cnt)
    );

    a_smoother #(.DATA_WIDTH(DW)) u_smoother (
        .i_a_cur(sm_cur), .i_a_new(sm_new), .i_shift(sm_shift), .o_a_next(sm_next)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_sof = 0, n_clr = 0, n_eof = 0, n_err = 0;
    int exp_a_q[$];
    int exp_z_q[$];
    int m_a = 0, m_z = 0, m_cnt = 0;
    bit m_valid = 1'b0;

    // Pulse tally, sampled mid-cycle.
    always @(negedge clk) begin
        if (sof)       n_sof++;
        if (calc_clr)  n_clr++;
        if (eof)       n_eof++;
        if (frame_err) n_err++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference IIR step using floored integer division.
    function automatic int iir(input int cur, input int nw, input int sh, input bit first);
        int d, q, dv;
        if (first || sh == 0) return nw;
        dv = 1 << sh;
        d  = nw - cur;
        q  = d / dv;
        if (d < 0 && (d % dv) != 0) q = q - 1;
        return cur + q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input string tag, input logic exp_err);
        vsync = 1'b1;
        tick();
        check_val({tag, "_sof"}, 32'(sof), 32'(1));
        check_val({tag, "_clr"}, 32'(calc_clr), 32'(1));
        check_val({tag, "_err"}, 32'(frame_err), 32'(exp_err));
        check_val({tag, "_xy"}, 32'({x_pos, y_pos}), 32'(0));
        vsync = 1'b0;
        tick();
        check_val({tag, "_sof_width"}, 32'(sof), 32'(0));
    endtask

    task automatic run_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
    endtask

    task automatic accept_a(input string tag, input int val, input logic with_vs);
        a_new       = DW'(val);
        a_new_valid = 1'b1;
        vsync       = with_vs;
        m_a = iir(m_a, val, 2, !m_valid);
        m_z = iir(m_z, val, 0, !m_valid);
        m_valid = 1'b1;
        m_cnt++;
        exp_a_q.push_back(m_a);
        exp_z_q.push_back(m_z);
        tick();
        a_new_valid = 1'b0;
        check_val({tag, "_a_cur"}, 32'(a_cur), 32'(exp_a_q.pop_front()));
        check_val({tag, "_a_cur_noshift"}, 32'(z_a_cur), 32'(exp_z_q.pop_front()));
        check_val({tag, "_a_valid"}, 32'(a_cur_valid), 32'(1));
        check_val({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(m_cnt));
        check_val({tag, "_err"}, 32'(frame_err), 32'(0));
        check_val({tag, "_sof"}, 32'(sof), 32'(with_vs));
        vsync = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; vsync = 1'b0; hsync = 1'b0; valid_in = 1'b0;
        a_new = '0; a_new_valid = 1'b0;

        // Stand-alone IIR step values.
        sm_cur = 8'd100; sm_new = 8'd200; sm_shift = 4'd2; #1;
        check_val("iir_up", 32'(sm_next), 32'(125));
        sm_cur = 8'd200; sm_new = 8'd100; #1;
        check_val("iir_down", 32'(sm_next), 32'(175));
        sm_shift = 4'd0; #1;
        check_val("iir_shift0", 32'(sm_next), 32'(100));

        tick(); tick(); tick();
        check_val("rst_outs", 32'({sof, calc_clr, eof, frame_err, a_cur_valid}), 32'(0));
        check_val("rst_a_cur", 32'(a_cur), 32'(0));
        check_val("rst_frame_cnt", 32'(frame_cnt), 32'(0));
        rst_n = 1'b1;
        tick();
        run_pixels(2);
        check_val("idle_pixels_x", 32'(x_pos), 32'(0));

        // Nominal frame with position tracking.
        start_frame("f1", 1'b0);
        for (int i = 0; i < W * H; i++) begin
            valid_in = 1'b1;
            tick();
            check_val("f1_x", 32'(x_pos), 32'((i + 1) % W));
            check_val("f1_y", 32'(y_pos), 32'(((i + 1) / W) % H));
            check_val("f1_eof", 32'(eof), 32'(i == W * H - 1));
        end
        valid_in = 1'b0;
        accept_a("f1", 200, 1'b0);
        check_val("f1_sof_count", 32'(n_sof), 32'(1));
        check_val("f1_clr_count", 32'(n_clr), 32'(1));
        check_val("f1_eof_count", 32'(n_eof), 32'(1));

        // Stray A during ACTIVE, then smoothing toward a lower value.
        start_frame("f2", 1'b0);
        run_pixels(3);
        a_new = 8'd55; a_new_valid = 1'b1;
        tick();
        a_new_valid = 1'b0;
        check_val("stray_a_cur", 32'(a_cur), 32'(200));
        run_pixels(5);
        check_val("f2_eof", 32'(eof), 32'(1));
        accept_a("f2", 100, 1'b0);

        // Short frame, then a full frame that times out waiting for A.
        start_frame("f3", 1'b0);
        run_pixels(5);
        check_val("f3_pos5", 32'({x_pos, y_pos}), 32'({2'd1, 1'b1}));
        start_frame("short", 1'b1);
        check_val("short_frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        run_pixels(W * H);
        check_val("f3_eof", 32'(eof), 32'(1));
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (k == TO - 1) check_val("timeout_early", 32'(frame_err), 32'(0));
            if (k == TO)     check_val("timeout_err", 32'(frame_err), 32'(1));
        end
        check_val("timeout_a_hold", 32'(a_cur), 32'(m_a));
        a_new = 8'd9; a_new_valid = 1'b1;
        tick();
        a_new_valid = 1'b0;
        check_val("idle_a_ignored", 32'(a_cur), 32'(m_a));
        check_val("idle_cnt_same", 32'(frame_cnt), 32'(m_cnt));

        // Short line, long frame, then A together with the next vsync.
        start_frame("f4", 1'b0);
        run_pixels(2);
        hsync = 1'b1;
        tick();
        check_val("short_line_err", 32'(frame_err), 32'(1));
        check_val("short_line_x", 32'(x_pos), 32'(2));
        hsync = 1'b0;
        run_pixels(6);
        check_val("f4_eof", 32'(eof), 32'(1));
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check_val("long_frame_err", 32'(frame_err), 32'(1));
        check_val("long_frame_x", 32'(x_pos), 32'(0));
        accept_a("simul", 50, 1'b1);

        // Reset mid-frame.
        run_pixels(3);
        check_val("f5_x", 32'(x_pos), 32'(3));
        rst_n = 1'b0;
        #1;
        check_val("async_rst_pos", 32'({x_pos, y_pos}), 32'(0));
        check_val("async_rst_a", 32'({a_cur, a_cur_valid}), 32'(0));
        check_val("async_rst_cnt", 32'(frame_cnt), 32'(0));
        check_val("async_rst_noshift_a", 32'(z_a_cur), 32'(0));
        tick();
        rst_n = 1'b1;
        run_pixels(3);
        check_val("post_rst_x", 32'(x_pos), 32'(0));
        check_val("total_sof", 32'(n_sof), 32'(6));
        check_val("total_eof", 32'(n_eof), 32'(4));
        check_val("total_err", 32'(n_err), 32'(4));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
